// File: rtl/onewire_rom_sequencer_if.sv
// Host-side handshake bundle for the 1-Wire ROM sequencer.
// start (host->seq), busy/done/presence_err/crc_err/rom_id[63:0] (seq->host).
interface onewire_rom_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        presence_err;
  logic        crc_err;
  logic [63:0] rom_id;

  modport master (
    output start,
    input  busy, done, presence_err, crc_err, rom_id
  );

  modport slave (
    input  start,
    output busy, done, presence_err, crc_err, rom_id
  );
endinterface

// File: rtl/onewire_rom_sequencer.sv
// 1-Wire master: reset/presence, Read ROM (0x33), 64-bit read + CRC-8.
// Ports: clk, rst (async high), bus (open-drain inout), host (slave modport).
module onewire_rom_sequencer #(
  parameter int CLKS_PER_US = 1
) (
  input  logic clk,
  input  logic rst,
  inout  wire  bus,
  onewire_rom_sequencer_if.slave host
);

  localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [7:0] CMD = 8'h33;

  typedef enum logic [2:0] {
    IDLE, RST_LOW, PRES_WAIT, PRES_RECOV, CMD_TX, ROM_RX, FINISH
  } state_t;

  state_t      state;
  logic [PW-1:0] pre;
  logic [8:0]  ucnt;
  logic [5:0]  bit_idx;
  logic [7:0]  crc;
  logic [63:0] shadow;
  logic        pres_ok;
  logic        bus_low;
  logic        busy_q;
  logic        done_q;
  logic        pres_err_q;
  logic        crc_err_q;
  logic [63:0] rom_q;

  logic       tick;
  logic       cmd_bit;
  logic [8:0] cmd_rel;
  logic       fb;
  logic [7:0] crc_next;

  // tick marks the last clk of each timing unit
  assign tick     = (pre == PW'(CLKS_PER_US - 1));
  assign cmd_bit  = CMD[bit_idx[2:0]];
  assign cmd_rel  = cmd_bit ? 9'd5 : 9'd59;
  assign fb       = crc[0] ^ bus;
  assign crc_next = {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);

  assign bus = bus_low ? 1'b0 : 1'bz;

  assign host.busy         = busy_q;
  assign host.done         = done_q;
  assign host.presence_err = pres_err_q;
  assign host.crc_err      = crc_err_q;
  assign host.rom_id       = rom_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pre        <= '0;
      ucnt       <= '0;
      bit_idx    <= '0;
      crc        <= '0;
      shadow     <= '0;
      pres_ok    <= 1'b0;
      bus_low    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pres_err_q <= 1'b0;
      crc_err_q  <= 1'b0;
      rom_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && state != FINISH)
        pre <= tick ? '0 : pre + 1'b1;
      unique case (state)
        IDLE: begin
          if (host.start) begin
            pres_err_q <= 1'b0;
            crc_err_q  <= 1'b0;
            busy_q     <= 1'b1;
            bus_low    <= 1'b1;
            ucnt       <= '0;
            pre        <= '0;
            state      <= RST_LOW;
          end
        end
        RST_LOW: begin
          if (tick) begin
            if (ucnt == 9'd479) begin
              ucnt    <= '0;
              bus_low <= 1'b0;
              state   <= PRES_WAIT;
            end else begin
              ucnt <= ucnt + 1'b1;
            end
          end
        end
        PRES_WAIT: begin
          if (tick) begin
            if (ucnt == 9'd69) begin
              ucnt       <= '0;
              pres_ok    <= ~bus;
              pres_err_q <= bus;
              state      <= PRES_RECOV;
            end else begin
              ucnt <= ucnt + 1'b1;
            end
          end
        end
        PRES_RECOV: begin
          if (tick) begin
            if (ucnt == 9'd409) begin
              ucnt    <= '0;
              bit_idx <= '0;
              if (pres_ok) begin
                bus_low <= 1'b1;
                state   <= CMD_TX;
              end else begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                state  <= FINISH;
              end
            end else begin
              ucnt <= ucnt + 1'b1;
            end
          end
        end
        CMD_TX: begin
          if (tick) begin
            if (ucnt == 9'd69) begin
              ucnt    <= '0;
              bus_low <= 1'b1;
              if (bit_idx[2:0] == 3'd7) begin
                bit_idx <= '0;
                crc     <= '0;
                state   <= ROM_RX;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              ucnt <= ucnt + 1'b1;
              if (ucnt == cmd_rel)
                bus_low <= 1'b0;
            end
          end
        end
        ROM_RX: begin
          if (tick) begin
            if (ucnt == 9'd69) begin
              ucnt <= '0;
              if (bit_idx == 6'd63) begin
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                crc_err_q <= |crc;
                if (crc == 8'h00)
                  rom_q <= shadow;
                state <= FINISH;
              end else begin
                bit_idx <= bit_idx + 1'b1;
                bus_low <= 1'b1;
              end
            end else begin
              ucnt <= ucnt + 1'b1;
              if (ucnt == 9'd5)
                bus_low <= 1'b0;
              // edge closing unit 15 of the slot
              if (ucnt == 9'd14) begin
                shadow[bit_idx] <= bus;
                crc             <= crc_next;
              end
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/onewire_rom_sequencer.md
# onewire_rom_sequencer

Master-side controller for the 1-Wire ROM identification transaction. It runs the full sequence on the shared open-drain `bus`: reset pulse, presence detect, Read ROM command (0x33), 64-bit ROM read with on-the-fly Dallas CRC-8 check. It is the top-level sequencer wrapped around the ROM-read datapath and takes one `start` pulse from the host logic.

## Interface
- `CLKS_PER_US`, default 1: clk cycles per 1 µs timing unit. All slot timings below are in units and scale by this value.
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `bus`  inout  1  1-Wire line; driven `1'b0` or `1'bz` only, never driven high; external pull-up
- `start`  in  1  request pulse; sampled only while `busy`=0
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle completion pulse
- `presence_err`  out  1  no device answered the reset; valid with `done`, held until next accepted `start`
- `crc_err`  out  1  CRC-8 residual non-zero; valid with `done`, held until next accepted `start`
- `rom_id`  out  64  received ROM, bit 0 = first bit received; updated only on a successful transaction (CRC good)

## Operation
- States: IDLE, RST_LOW, PRES_WAIT, PRES_RECOV, CMD_TX, ROM_RX, FINISH.
- IDLE: bus released. `start`=1 -> clear `presence_err`/`crc_err`, set `busy`, go to RST_LOW.
- RST_LOW: drive bus low for 480 units, then release and go to PRES_WAIT.
- PRES_WAIT: sample bus 70 units after release. Low -> presence OK. High -> set `presence_err`. Go to PRES_RECOV.
- PRES_RECOV: bus released for the remaining 410 units. Then presence OK -> CMD_TX; otherwise FINISH.
- CMD_TX: send 0x33 LSB-first, 8 slots of 70 units each.
  - bit=1: drive low 6 units, release 64 units.
  - bit=0: drive low 60 units, release 10 units.
- ROM_RX: 64 read slots of 70 units each.
  - Drive low 6 units, release, sample bus at unit 15 of the slot.
  - Shift the sampled bit into a shadow register at index = slot number.
  - Update CRC on the sampled bit: `fb = crc[0]^bit; crc = crc>>1; if fb: crc ^= 8'h8C`. CRC init 0.
- FINISH (one cycle):
  - `done`=1 and `busy`=0.
  - If the transaction was not aborted: `crc_err` = (crc != 0). If crc == 0, copy the shadow register to `rom_id`.
  - Return to IDLE.
- `start` while `busy`=1 is ignored. `start` in the FINISH cycle is ignored. `start` in the first IDLE cycle after FINISH is accepted.
- Bus is only ever driven to 0 or z. The bus is released in every state except the low phases.

## Timing
- Reset values: `busy`=0, `done`=0, `presence_err`=0, `crc_err`=0, `rom_id`=0, bus=z, state IDLE, all counters and CRC cleared.
- `rst` mid-transaction releases the bus immediately (asynchronously). No `done` pulse is generated.
- Let E0 be the edge at which `start` is sampled.
  - Bus goes low from E0; `busy`=1 from E0.
  - Each phase boundary falls on an exact multiple of `CLKS_PER_US` cycles after E0.
- Normal transaction (480+480+8·70+64·70 = 6000 units): `done` is high in the cycle starting at edge E0 + 6000·`CLKS_PER_US`.
- Presence failure: `done` is high in the cycle starting at edge E0 + 960·`CLKS_PER_US`.
- Sampling point: the clk edge that ends unit 15 of the read slot; for presence, unit 70 after release.
- `done` is a single-cycle pulse and never asserts outside FINISH.

## Test plan
- Device model returns AN27 ROM 64'hA200_0000_01B8_1C02, `CLKS_PER_US`=1 -> `done` at E0+6000, `crc_err`=0, `presence_err`=0, `rom_id`=64'hA200_0000_01B8_1C02.
- Same ROM with bit 40 flipped -> `crc_err`=1, `rom_id` keeps previous value, `done` timing unchanged.
- No device (bus stays high) -> `presence_err`=1, `done` at E0+960, no further bus low pulses.
- Bus monitor during CMD_TX with `CLKS_PER_US`=4 -> low widths of 24/24/240/240/24/24/240/240 cycles (0x33 LSB-first), slot period 280 cycles.
- `rst` asserted at E0+3000 -> bus z in the same cycle, all outputs 0. A new `start` afterwards completes normally.
- `start` held high continuously -> transactions back-to-back, each new E0 two cycles after the previous `done` edge. `start` during `busy` has no effect.
